remainder_by_any_divisor_4_16_4: RTL and testbench
==================================================

Name: remainder_by_any_divisor_4_16_4

Overview:
- Front/back-end sequencer that computes dividend mod divisor for any 4-bit divisor.
- Upstream side: normalises the divisor by shifting left until its MSB is 1 (shift count k), then launches the existing MSB-1 remainder unit through a start/ready port pair.
- Downstream side: reduces the returned remainder r' (r' = dividend mod (divisor<<k)) by the original divisor in k shift-subtract steps.
- The MSB-1 unit is external, wired at the top level; this block does not instantiate it.

Parameters:
- DIVIDEND_W, 16, dividend width (fixed for this variant; other values are not required to work).
- DIVISOR_W, 4, divisor, result and shift-count source width (fixed for this variant).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request pulse; operands sampled the same cycle
- dividend  in  16  numerator
- divisor  in  4  denominator, any value 0..15
- result  out  4  dividend mod divisor; valid while result_ready=1
- result_ready  out  1  idle/done flag; forced low whenever start=1
- div_by_zero  out  1  set when the last request had divisor=0
- rem_start  out  1  one-cycle launch pulse to the MSB-1 unit
- rem_dividend  out  16  latched dividend, held stable from launch until capture
- rem_divisor  out  4  normalised divisor (bit3=1), held stable from launch until capture
- rem_result  in  4  r' from the MSB-1 unit
- rem_ready  in  1  MSB-1 unit idle/done flag; low the cycle after its start

Behaviour:
- Reset values:
  - state IDLE
  - result=0, div_by_zero=0, rem_start=0
  - rem_dividend=0, rem_divisor=0
  - internal k=0
  - result_ready=1 (unless start=1)
- start has priority over every state, including reset-free abort:
  - latch dividend and divisor, clear div_by_zero, k=0, go to NORM.
  - reset has priority over start.
- States:
  - IDLE: hold result and div_by_zero.
  - NORM:
    - If latched divisor=0: div_by_zero<=1, result<=0, go to IDLE.
    - Else if dn[3]=0: dn<=dn<<1, k<=k+1, stay.
    - Else go to LAUNCH.
    - Takes k+1 cycles; k is at most 3.
  - LAUNCH: rem_start=1 for exactly this cycle; drive rem_dividend/rem_divisor; go to GUARD.
  - GUARD: one cycle that ignores rem_ready (the MSB-1 unit's ready is stale here); go to WAIT.
  - WAIT:
    - When rem_ready=1, capture r<=rem_result.
    - If k=0, result<=rem_result and go to IDLE; else t<=divisor<<(k-1) and go to FIX.
    - No timeout.
  - FIX: one step per cycle.
    - If r>=t then r<=r-t.
    - t<=t>>1, k<=k-1.
    - When k reaches 1 on a step, write the final r to result and go to IDLE.
    - Takes exactly k cycles.
- Arithmetic:
  - All FIX values fit in 4 bits (t<=dn<=15, r<dn); unsigned compare.
  - r' < divisor<<k guarantees the k steps fully reduce r' mod divisor.
- result_ready = (state==IDLE) & ~start.
- Latency: start in cycle 0 → result_ready=1 in cycle 2 for divisor 0. Otherwise cycle 0 + (k+1) NORM + 1 LAUNCH + 1 GUARD + WAIT + k FIX + 1.
- start during any busy state aborts the current request. A re-issued rem_start restarts the MSB-1 unit, so no stale r' is captured. Only the newest request is reported.
- A start with divisor=0 never pulses rem_start.
- Back-to-back start pulses in consecutive cycles: the last one wins.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=0, NORM=1, LAUNCH=2, GUARD=3, WAIT=4, FIX=5
  - DIVIDEND_W and DIVISOR_W
- One natural sub-module: remainder_fixup_step_4, combinational one-step compare/subtract/shift on (r, t). Everything else stays in a single FSM.

Test Plan:
- The bench contains a behavioural MSB-1 unit model with 1..20 cycle random latency and ready semantics matching the MSB-1 unit's start/ready protocol.
- 100 mod 9: k=0, no FIX cycles; result=1; rem_divisor=9; exactly one rem_start pulse.
- 1000 mod 3: dn=12, k=2; model returns 4; 2 FIX cycles → result=1.
- 65535 mod 1: dn=8, k=3; model returns 7 → result=0. Also 5 mod 7: dn=14, r'=5 → result=5.
- divisor=0, dividend=1234: div_by_zero=1, result=0, no rem_start; result_ready=1 in cycle 2.
- Request 1000 mod 3, then start 77 mod 10 while in WAIT: second rem_start issued; only result=7 reported; result_ready stays low until then.
- reset asserted in FIX: next cycle IDLE, result=0, div_by_zero=0, result_ready=1, rem_start=0.

Source files
------------

// File: rtl/remainder_by_any_divisor_4_16_4_pkg.sv
// Shared definitions for the any-divisor remainder sequencer: widths,
// FSM state encoding and the fix-up threshold helper.
package remainder_by_any_divisor_4_16_4_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 4;
  // Normalisation shift count never exceeds 3 for a nonzero 4-bit divisor.
  localparam int K_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NORM   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_GUARD  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_FIX    = 3'd5
  } state_t;

  // First fix-up threshold: divisor << (k-1). Since divisor << k is the
  // normalised divisor (<= 15), the result always fits in 4 bits.
  function automatic logic [DIVISOR_W-1:0] fix_threshold(
    input logic [DIVISOR_W-1:0] d,
    input logic [K_W-1:0]       k
  );
    logic [DIVISOR_W-1:0] t;
    case (k)
      2'd1:    t = d;
      2'd2:    t = {d[2:0], 1'b0};
      2'd3:    t = {d[1:0], 2'b00};
      default: t = d;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/remainder_by_any_divisor_4_16_4_fixup.sv
// One restoring-reduction step on (r, t): subtract t from r when it fits,
// then halve the threshold for the next step.
module remainder_fixup_step_4
  import remainder_by_any_divisor_4_16_4_pkg::*;
(
  input  logic [DIVISOR_W-1:0] i_r,
  input  logic [DIVISOR_W-1:0] i_t,
  output logic [DIVISOR_W-1:0] o_r,
  output logic [DIVISOR_W-1:0] o_t,
  output logic                 o_sub
);

  // Unsigned compare/subtract of r against t, and threshold shift.
  always_comb begin
    o_sub = (i_r >= i_t);
    if (o_sub) begin
      o_r = i_r - i_t;
    end else begin
      o_r = i_r;
    end
    o_t = i_t >> 1;
  end

endmodule

// File: rtl/remainder_by_any_divisor_4_16_4.sv
// Any-divisor remainder sequencer. Normalises the divisor so its MSB is set,
// hands the request to an external MSB-1 remainder unit, then reduces the
// returned remainder (mod divisor<<k) down to mod divisor in k steps.
module remainder_by_any_divisor_4_16_4
  import remainder_by_any_divisor_4_16_4_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W-1:0]  result,
  output logic                  result_ready,
  output logic                  div_by_zero,
  output logic                  rem_start,
  output logic [DIVIDEND_W-1:0] rem_dividend,
  output logic [DIVISOR_W-1:0]  rem_divisor,
  input  logic [DIVISOR_W-1:0]  rem_result,
  input  logic                  rem_ready
);

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_dividend;
  logic [DIVISOR_W-1:0]  r_div;       // original divisor
  logic [DIVISOR_W-1:0]  r_dn;        // normalised divisor
  logic [K_W-1:0]        r_k;
  logic [DIVISOR_W-1:0]  r_r;
  logic [DIVISOR_W-1:0]  r_t;
  logic [DIVISOR_W-1:0]  r_result;
  logic                  r_dbz;
  logic                  r_rem_start;

  state_t                w_state;
  logic [DIVIDEND_W-1:0] w_dividend;
  logic [DIVISOR_W-1:0]  w_div;
  logic [DIVISOR_W-1:0]  w_dn;
  logic [K_W-1:0]        w_k;
  logic [DIVISOR_W-1:0]  w_r;
  logic [DIVISOR_W-1:0]  w_t;
  logic [DIVISOR_W-1:0]  w_result;
  logic                  w_dbz;
  logic                  w_rem_start;

  logic [DIVISOR_W-1:0]  w_fix_r;
  logic [DIVISOR_W-1:0]  w_fix_t;
  logic                  w_fix_sub;

  remainder_fixup_step_4 u_fixup (
    .i_r   (r_r),
    .i_t   (r_t),
    .o_r   (w_fix_r),
    .o_t   (w_fix_t),
    .o_sub (w_fix_sub)
  );

  // Next-state and datapath update; a new start aborts whatever is in flight.
  always_comb begin
    w_state    = r_state;
    w_dividend = r_dividend;
    w_div      = r_div;
    w_dn       = r_dn;
    w_k        = r_k;
    w_r        = r_r;
    w_t        = r_t;
    w_result   = r_result;
    w_dbz      = r_dbz;

    if (start) begin
      w_dividend = dividend;
      w_div      = divisor;
      w_dn       = divisor;
      w_k        = 2'd0;
      w_dbz      = 1'b0;
      w_state    = ST_NORM;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state = ST_IDLE;
        end
        ST_NORM: begin
          if (r_div == 4'd0) begin
            w_dbz    = 1'b1;
            w_result = 4'd0;
            w_state  = ST_IDLE;
          end else if (!r_dn[DIVISOR_W-1]) begin
            w_dn = {r_dn[DIVISOR_W-2:0], 1'b0};
            w_k  = r_k + 2'd1;
          end else begin
            w_state = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          w_state = ST_GUARD;
        end
        ST_GUARD: begin
          // The unit's ready flag may still reflect the previous job here.
          w_state = ST_WAIT;
        end
        ST_WAIT: begin
          if (rem_ready) begin
            w_r = rem_result;
            if (r_k == 2'd0) begin
              w_result = rem_result;
              w_state  = ST_IDLE;
            end else begin
              w_t     = fix_threshold(r_div, r_k);
              w_state = ST_FIX;
            end
          end else begin
            w_state = ST_WAIT;
          end
        end
        ST_FIX: begin
          w_r = w_fix_r;
          w_t = w_fix_t;
          w_k = r_k - 2'd1;
          if (r_k == 2'd1) begin
            w_result = w_fix_r;
            w_state  = ST_IDLE;
          end else begin
            w_state = ST_FIX;
          end
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end

    // Launch pulse is registered so it is high exactly in the LAUNCH cycle.
    w_rem_start = (w_state == ST_LAUNCH);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dividend  <= 16'd0;
      r_div       <= 4'd0;
      r_dn        <= 4'd0;
      r_k         <= 2'd0;
      r_r         <= 4'd0;
      r_t         <= 4'd0;
      r_result    <= 4'd0;
      r_dbz       <= 1'b0;
      r_rem_start <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_dividend  <= w_dividend;
      r_div       <= w_div;
      r_dn        <= w_dn;
      r_k         <= w_k;
      r_r         <= w_r;
      r_t         <= w_t;
      r_result    <= w_result;
      r_dbz       <= w_dbz;
      r_rem_start <= w_rem_start;
    end
  end

  assign result       = r_result;
  assign div_by_zero  = r_dbz;
  assign rem_start    = r_rem_start;
  assign rem_dividend = r_dividend;
  assign rem_divisor  = r_dn;
  assign result_ready = (r_state == ST_IDLE) & ~start;

endmodule

// File: tb/tb_remainder_by_any_divisor_4_16_4.sv
// Directed bench for the any-divisor remainder sequencer, with a behavioural
// MSB-1 remainder unit of random latency on the rem_* port pair.
module tb_remainder_by_any_divisor_4_16_4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [3:0]  divisor;
  logic [3:0]  result;
  logic        result_ready;
  logic        div_by_zero;
  logic        rem_start;
  logic [15:0] rem_dividend;
  logic [3:0]  rem_divisor;
  logic [3:0]  rem_result;
  logic        rem_ready;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int n_rs    = 0;

  // MSB-1 unit model state
  logic        m_ready = 1'b1;
  logic [3:0]  m_res   = 4'd0;
  int          m_cnt   = 0;
  int          m_force_lat = 0;
  int          m_lat_last  = 0;
  int          lat;
  logic [15:0] m_tmp;

  always #5 clk = ~clk;

  remainder_by_any_divisor_4_16_4 dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .result       (result),
    .result_ready (result_ready),
    .div_by_zero  (div_by_zero),
    .rem_start    (rem_start),
    .rem_dividend (rem_dividend),
    .rem_divisor  (rem_divisor),
    .rem_result   (rem_result),
    .rem_ready    (rem_ready)
  );

  assign rem_result = m_res;
  assign rem_ready  = m_ready;

  // Behavioural MSB-1 unit: ready drops the cycle after start, returns
  // dividend mod divisor after 1..20 cycles; a new start restarts it.
  always @(posedge clk) begin
    if (reset) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_res   <= 4'd0;
    end else if (rem_start) begin
      lat = (m_force_lat > 0) ? m_force_lat : int'($urandom_range(20, 1));
      m_tmp = (rem_divisor == 4'd0) ? 16'd0 : (rem_dividend % {12'd0, rem_divisor});
      m_ready    <= 1'b0;
      m_cnt      <= lat;
      m_lat_last <= lat;
      m_res      <= m_tmp[3:0];
    end else if (!m_ready) begin
      if (m_cnt <= 1) m_ready <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  // Count launch pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rem_start === 1'b1) n_rs++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start pulse; returns at cycle 1 of the request.
  task automatic pulse_start(input logic [15:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    #1;
    check("rr_low_during_start", 32'(result_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Wait (bounded) for result_ready; cyc is the cycle index after start.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (result_ready !== 1'b1 && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("done_within_bound", 32'(result_ready), 32'd1);
  endtask

  // Wait (bounded) for the LAUNCH cycle.
  task automatic wait_launch();
    int i;
    i = 0;
    while (rem_start !== 1'b1 && i < 40) begin
      @(negedge clk); #1;
      i++;
    end
    check("launch_seen", 32'(rem_start), 32'd1);
  endtask

  initial begin
    int cyc;
    int rs0;
    reset = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_result", 32'(result), 32'd0);
    check("rst_rr", 32'(result_ready), 32'd1);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_rem_start", 32'(rem_start), 32'd0);
    check("rst_rem_dividend", 32'(rem_dividend), 32'd0);
    check("rst_rem_divisor", 32'(rem_divisor), 32'd0);
    reset = 1'b0;

    // 100 mod 9: k=0
    rs0 = n_rs;
    pulse_start(16'd100, 4'd9);
    wait_done(cyc);
    check("m9_result", 32'(result), 32'd1);
    check("m9_rem_divisor", 32'(rem_divisor), 32'd9);
    check("m9_rem_dividend", 32'(rem_dividend), 32'd100);
    check("m9_launches", 32'(n_rs - rs0), 32'd1);
    check("m9_latency", 32'(cyc), 32'(m_lat_last + 4));
    check("m9_dbz", 32'(div_by_zero), 32'd0);

    // 1000 mod 3: dn=12, k=2, r'=4
    pulse_start(16'd1000, 4'd3);
    wait_done(cyc);
    check("m3_result", 32'(result), 32'd1);
    check("m3_rem_divisor", 32'(rem_divisor), 32'd12);
    check("m3_latency", 32'(cyc), 32'(m_lat_last + 8));

    // 65535 mod 1: dn=8, k=3, r'=7
    pulse_start(16'd65535, 4'd1);
    wait_done(cyc);
    check("m1_result", 32'(result), 32'd0);
    check("m1_rem_divisor", 32'(rem_divisor), 32'd8);
    check("m1_latency", 32'(cyc), 32'(m_lat_last + 10));

    // 5 mod 7: dn=14, k=1, r'=5
    pulse_start(16'd5, 4'd7);
    wait_done(cyc);
    check("m7_result", 32'(result), 32'd5);
    check("m7_rem_divisor", 32'(rem_divisor), 32'd14);
    check("m7_latency", 32'(cyc), 32'(m_lat_last + 6));

    // divisor 0: ready in cycle 2, no launch
    rs0 = n_rs;
    pulse_start(16'd1234, 4'd0);
    check("dz_rr_cycle1", 32'(result_ready), 32'd0);
    @(negedge clk); #1;
    check("dz_rr_cycle2", 32'(result_ready), 32'd1);
    check("dz_flag", 32'(div_by_zero), 32'd1);
    check("dz_result", 32'(result), 32'd0);
    check("dz_no_launch", 32'(n_rs - rs0), 32'd0);

    // Abort during WAIT: 1000 mod 3 superseded by 77 mod 10
    m_force_lat = 20;
    rs0 = n_rs;
    pulse_start(16'd1000, 4'd3);
    check("dz_cleared_on_start", 32'(div_by_zero), 32'd0);
    wait_launch();
    @(negedge clk); #1;
    check("ab_rr_low_guard", 32'(result_ready), 32'd0);
    m_force_lat = 3;
    pulse_start(16'd77, 4'd10);
    wait_done(cyc);
    check("ab_result", 32'(result), 32'd7);
    check("ab_latency", 32'(cyc), 32'd7);
    check("ab_launches", 32'(n_rs - rs0), 32'd2);
    check("ab_rem_divisor", 32'(rem_divisor), 32'd10);
    check("ab_rem_dividend", 32'(rem_dividend), 32'd77);

    // Back-to-back starts: the last wins
    m_force_lat = 0;
    rs0 = n_rs;
    @(negedge clk);
    start = 1'b1; dividend = 16'd5; divisor = 4'd7;
    @(negedge clk);
    dividend = 16'd100; divisor = 4'd9;
    #1;
    check("bb_rr_low", 32'(result_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_done(cyc);
    check("bb_result", 32'(result), 32'd1);
    check("bb_launches", 32'(n_rs - rs0), 32'd1);
    check("bb_latency", 32'(cyc), 32'(m_lat_last + 4));

    // Reset while in FIX (65535 mod 1, latency 2 -> FIX 4 cycles after LAUNCH)
    m_force_lat = 2;
    pulse_start(16'd65535, 4'd1);
    wait_launch();
    repeat (4) @(negedge clk);
    #1;
    check("rf_busy_in_fix", 32'(result_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rf_rr", 32'(result_ready), 32'd1);
    check("rf_result", 32'(result), 32'd0);
    check("rf_dbz", 32'(div_by_zero), 32'd0);
    check("rf_rem_start", 32'(rem_start), 32'd0);
    check("rf_rem_divisor", 32'(rem_divisor), 32'd0);
    reset = 1'b0;
    m_force_lat = 0;

    // Recovery after reset
    pulse_start(16'd1000, 4'd3);
    wait_done(cyc);
    check("rec_result", 32'(result), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
